// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters
// A granted requester owns the transmitter for a whole message; a mid-message stall is reclaimed by timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int IDLE_TIMEOUT = 100000,
  parameter int ACK_WAIT     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACK_W  = ($clog2(ACK_WAIT + 1) > 3) ? $clog2(ACK_WAIT + 1) : 3;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     last_ptr_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [IDLE_W-1:0]    idle_cnt_q;
  logic [IDLE_W-1:0]    idle_cnt_d;
  logic [ACK_W-1:0]     ack_cnt_q;
  logic [7:0]           tx_data_q;
  logic                 tx_send_q;
  logic                 timeout_q;
  logic                 last_flag_q;
  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  int                   arb_idx;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    arb_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = int'(last_ptr_q) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!pick_found && req_valid[arb_idx]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(arb_idx);
      end
    end
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_ptr_q  <= PTR_W'(NUM_REQ - 1);
      gidx_q      <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      idle_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      timeout_q   <= 1'b0;
      last_flag_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      tx_send_q   <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q    <= NUM_REQ'(1) << pick_idx;
            gidx_q     <= pick_idx;
            idle_cnt_q <= '0;
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (req_valid[gidx_q]) begin
            tx_data_q   <= req_data[{gidx_q, 3'b000} +: 8];
            last_flag_q <= req_last[gidx_q];
            req_ready_q <= grant_q;
            tx_send_q   <= 1'b1;
            ack_cnt_q   <= '0;
            state_q     <= S_WAIT_ACK;
          end else begin
            idle_cnt_q <= idle_cnt_d;
            if (idle_cnt_d == IDLE_MAX) begin
              timeout_q  <= 1'b1;
              grant_q    <= '0;
              last_ptr_q <= gidx_q;
              state_q    <= S_IDLE;
            end
          end
        end
        S_WAIT_ACK: begin
          // A transmitter that never raises busy must not hang the arbiter.
          if (tx_busy || ack_cnt_q == ACK_LAST) state_q <= S_WAIT_DONE;
          else ack_cnt_q <= ack_cnt_q + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag_q) begin
              grant_q    <= '0;
              last_ptr_q <= gidx_q;
              state_q    <= S_IDLE;
            end else begin
              idle_cnt_q <= '0;
              state_q    <= S_XFER;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// A behavioural uart_tx busy model and an event log feed hand-computed expectations.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_last = '0;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic        timeout;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(3), .IDLE_TIMEOUT(16), .ACK_WAIT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .timeout(timeout),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit busy_mode = 1'b0;
  int busy_len = 20;
  int rem = 0;
  bit pend = 1'b0;
  logic [2:0] prev_grant = '0;
  int send_q[$], send_t[$], ready_q[$], gv[$], gt[$], gdrop_t[$], to_t[$];
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_log();
    @(negedge clk);
    send_q.delete(); send_t.delete(); ready_q.delete();
    gv.delete(); gt.delete(); gdrop_t.delete(); to_t.delete();
  endtask

  task automatic wait_ready(input int r);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (req_ready[r]) return;
    end
    check($sformatf("ready_wait_r%0d", r), 0, 1);
  endtask

  task automatic drive_msg(input int r, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      req_valid[r] = 1'b1;
      req_data[r*8 +: 8] = base + 8'(i);
      req_last[r] = (i == n - 1);
      wait_ready(r);
    end
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask

  // uart_tx model: busy rises the cycle after send and lasts busy_len cycles.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (pend) begin rem = busy_len; pend = 1'b0; end
    tx_busy = busy_mode && (rem > 0);
    if (rem > 0) rem--;
    if (tx_send) begin
      check("send_while_busy", 32'(tx_busy), 0);
      pend = busy_mode;
      send_q.push_back(int'(tx_data));
      send_t.push_back(cyc);
    end
    if (req_ready != 3'b000) ready_q.push_back(int'(req_ready));
    if (grant != 3'b000 && prev_grant == 3'b000) begin gv.push_back(int'(grant)); gt.push_back(cyc); end
    if (grant == 3'b000 && prev_grant != 3'b000) gdrop_t.push_back(cyc);
    if (timeout) to_t.push_back(cyc);
    check("grant_onehot0", 32'($onehot0(grant)), 1);
    prev_grant = grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_c[8];
    int exp_r[8];
    exp_c = '{'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h12, 'h13};
    exp_r = '{1, 1, 2, 2, 4, 4, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_data", 32'(tx_data), 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_grant", 32'(grant), 0);

    // Contention from reset: strict rotation, req0's re-request goes last.
    busy_mode = 1'b1; busy_len = 3;
    clear_log();
    fork
      begin drive_msg(0, 2, 8'h10); drive_msg(0, 2, 8'h12); end
      drive_msg(1, 2, 8'h20);
      drive_msg(2, 2, 8'h30);
    join
    repeat (20) @(posedge clk);
    check("cont_count", 32'(send_q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("cont_data%0d", i), 32'(qat(send_q, i)), 32'(exp_c[i]));
      check($sformatf("cont_ready%0d", i), 32'(qat(ready_q, i)), 32'(exp_r[i]));
    end
    check("cont_g0", 32'(qat(gv, 0)), 1);
    check("cont_g1", 32'(qat(gv, 1)), 2);
    check("cont_g2", 32'(qat(gv, 2)), 4);
    check("cont_g3", 32'(qat(gv, 3)), 1);

    // Single requester with 20-cycle busy: latency and inter-byte gap.
    busy_len = 20;
    clear_log();
    t0 = cyc;
    drive_msg(1, 3, 8'h41);
    repeat (30) @(posedge clk);
    check("single_gt", 32'(qat(gt, 0)), 32'(t0 + 1));
    check("single_gv", 32'(qat(gv, 0)), 2);
    check("single_count", 32'(send_q.size()), 3);
    check("single_d0", 32'(qat(send_q, 0)), 'h41);
    check("single_d1", 32'(qat(send_q, 1)), 'h42);
    check("single_d2", 32'(qat(send_q, 2)), 'h43);
    check("single_t0", 32'(qat(send_t, 0)), 32'(t0 + 2));
    check("single_gap1", 32'(qat(send_t, 1) - qat(send_t, 0)), 23);
    check("single_gap2", 32'(qat(send_t, 2) - qat(send_t, 1)), 23);
    check("single_rdy_n", 32'(ready_q.size()), 3);
    for (int i = 0; i < 3; i++) check($sformatf("single_rdy%0d", i), 32'(qat(ready_q, i)), 2);
    check("single_drop", 32'(qat(gdrop_t, 0)), 32'(qat(send_t, 2) + 22));

    // Missing ack: busy never rises.
    busy_mode = 1'b0;
    clear_log();
    drive_msg(2, 2, 8'h55);
    repeat (15) @(posedge clk);
    check("noack_count", 32'(send_q.size()), 2);
    check("noack_d1", 32'(qat(send_q, 1)), 'h56);
    check("noack_gap", 32'(qat(send_t, 1) - qat(send_t, 0)), 6);
    check("noack_drop", 32'(qat(gdrop_t, 0)), 32'(qat(send_t, 1) + 5));

    // One-byte message releases after one byte.
    clear_log();
    drive_msg(1, 1, 8'h77);
    repeat (15) @(posedge clk);
    check("onebyte_count", 32'(send_q.size()), 1);
    check("onebyte_data", 32'(qat(send_q, 0)), 'h77);
    check("onebyte_rdy_n", 32'(ready_q.size()), 1);
    check("onebyte_drop", 32'(qat(gdrop_t, 0)), 32'(qat(send_t, 0) + 5));

    // Stall timeout, pending req2 granted afterwards.
    clear_log();
    t0 = cyc;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h99; req_last[0] = 1'b0;
    wait_ready(0);
    req_valid[0] = 1'b0;
    req_valid[2] = 1'b1; req_data[23:16] = 8'hAA; req_last[2] = 1'b1;
    wait_ready(2);
    req_valid[2] = 1'b0; req_last[2] = 1'b0;
    repeat (15) @(posedge clk);
    check("to_count", 32'(to_t.size()), 1);
    check("to_cycle", 32'(qat(to_t, 0)), 32'(t0 + 23));
    check("to_drop", 32'(qat(gdrop_t, 0)), 32'(t0 + 23));
    check("to_regrant_t", 32'(qat(gt, 1)), 32'(t0 + 24));
    check("to_regrant_v", 32'(qat(gv, 1)), 4);
    check("to_d0", 32'(qat(send_q, 0)), 'h99);
    check("to_d1", 32'(qat(send_q, 1)), 'hAA);
    check("to_rdy_n", 32'(ready_q.size()), 2);
    check("to_rdy1", 32'(qat(ready_q, 1)), 4);

    // Async reset in WAIT_DONE.
    busy_mode = 1'b1; busy_len = 20;
    clear_log();
    req_valid[1] = 1'b1; req_data[15:8] = 8'h61; req_last[1] = 1'b0;
    wait_ready(1);
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_grant", 32'(grant), 2);
    reset = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 0);
    check("arst_data", 32'(tx_data), 0);
    check("arst_ready", 32'(req_ready), 0);
    check("arst_send", 32'(tx_send), 0);
    check("arst_timeout", 32'(timeout), 0);
    rem = 0; pend = 1'b0; tx_busy = 1'b0;
    req_last[1] = 1'b1;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h01; req_last[0] = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ready(0);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    wait_ready(1);
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    repeat (30) @(posedge clk);
    check("arst_first_g", 32'(qat(gv, 0)), 1);
    check("arst_rdy_n", 32'(ready_q.size()), 2);
    check("arst_rdy0", 32'(qat(ready_q, 0)), 1);
    check("arst_rdy1", 32'(qat(ready_q, 1)), 2);
    check("arst_d0", 32'(qat(send_q, 0)), 'h01);
    check("arst_d1", 32'(qat(send_q, 1)), 'h61);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
